// File: rtl/ras_pkg.sv
// Shared return-address-stack definitions: sizes, entry layout and the
// count normalisation used on restore.
// Optional feature macro: RAS_RECURSION_CNT_EN (recursion merge / counted pops).
package ras_pkg;

    localparam int RAS_DEPTH   = 16;
    localparam int RAS_PTR_W   = 4;
    localparam int RAS_CNT_W   = 7;
    localparam int RAS_CNT_MAX = 127;
    localparam int RAS_ADDR_W  = 32;

    typedef logic [RAS_PTR_W-1:0]  ras_ptr_t;
    typedef logic [RAS_CNT_W-1:0]  ras_cnt_t;
    typedef logic [RAS_ADDR_W-1:0] ras_addr_t;

    typedef struct packed {
        ras_addr_t addr;
        ras_cnt_t  cnt;
    } ras_entry_t;

    // Without recursion counting an entry is either empty (0) or live (1).
    function automatic ras_cnt_t ras_norm_cnt(input ras_cnt_t c);
`ifdef RAS_RECURSION_CNT_EN
        return c;
`else
        return (c != '0) ? ras_cnt_t'(1) : ras_cnt_t'(0);
`endif
    endfunction

endpackage

// File: rtl/ras_stack_array.sv
// Entry storage for the return address stack: three indexed write ports
// (port 0 has priority) and three read ports at ptr, ptr-1, ptr-2.
// The whole array clears on reset, so it is built from flops.
module ras_stack_array
    import ras_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] we_i,
    input  ras_ptr_t   widx_i  [3],
    input  ras_entry_t wdata_i [3],
    input  ras_ptr_t   rptr_i,
    output ras_entry_t rd0_o,
    output ras_entry_t rd1_o,
    output ras_entry_t rd2_o
);

    ras_entry_t entry_q [RAS_DEPTH];
    ras_ptr_t   ptr_m1;
    ras_ptr_t   ptr_m2;

    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
            // Each entry takes the first write port that addresses it.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    entry_q[gi] <= '0;
                end else if (we_i[0] && (widx_i[0] == ras_ptr_t'(gi))) begin
                    entry_q[gi] <= wdata_i[0];
                end else if (we_i[1] && (widx_i[1] == ras_ptr_t'(gi))) begin
                    entry_q[gi] <= wdata_i[1];
                end else if (we_i[2] && (widx_i[2] == ras_ptr_t'(gi))) begin
                    entry_q[gi] <= wdata_i[2];
                end
            end
        end
    endgenerate

    // Pointer arithmetic wraps modulo the depth.
    assign ptr_m1 = rptr_i - ras_ptr_t'(1);
    assign ptr_m2 = rptr_i - ras_ptr_t'(2);

    assign rd0_o = entry_q[rptr_i];
    assign rd1_o = entry_q[ptr_m1];
    assign rd2_o = entry_q[ptr_m2];

endmodule

// File: rtl/ras_predictor.sv
// Speculative return address stack: push on call, pop on return, rewind
// from a committed snapshot. Exports pointer plus top three entries.
// Optional feature macro: RAS_RECURSION_CNT_EN (recursion merge / counted pops).
module ras_predictor
    import ras_pkg::*;
(
    input  logic        Clk,
    input  logic        Rest,
    input  logic        RasStop,
    input  logic        RasPush,
    input  logic [31:0] RasPushPc,
    input  logic        RasPop,
    input  logic        UpRasReLoad,
    input  logic        UpRasAble,
    input  logic [3:0]  UpRasPtr,
    input  logic [31:0] UpRasStack1,
    input  logic [31:0] UpRasStack2,
    input  logic [31:0] UpRasStack3,
    input  logic [6:0]  UpRasStackC1,
    input  logic [6:0]  UpRasStackC2,
    input  logic [6:0]  UpRasStackC3,
    output logic [31:0] RasStackPc,
    output logic        RasStackValid,
    output logic [3:0]  RasStackPtr,
    output logic [31:0] RasStack1,
    output logic [31:0] RasStack2,
    output logic [31:0] RasStack3,
    output logic [6:0]  RsaSrackC1,
    output logic [6:0]  RsaSrackC2,
    output logic [6:0]  RsaSrackC3
);

    ras_ptr_t   ptr_q, ptr_d;
    logic [2:0] we;
    ras_ptr_t   widx  [3];
    ras_entry_t wdata [3];
    ras_entry_t top, nxt1, nxt2;
    logic       restore;

    assign restore = UpRasReLoad && UpRasAble;

    ras_stack_array u_array (
        .clk_i   (Clk),
        .rst_i   (Rest),
        .we_i    (we),
        .widx_i  (widx),
        .wdata_i (wdata),
        .rptr_i  (ptr_q),
        .rd0_o   (top),
        .rd1_o   (nxt1),
        .rd2_o   (nxt2)
    );

    // Top pointer register.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Next pointer and entry writes: restore beats freeze beats push/pop.
    always_comb begin
        ptr_d = ptr_q;
        we    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            widx[i]  = ptr_q;
            wdata[i] = '0;
        end

        if (restore) begin
            ptr_d    = UpRasPtr;
            we       = 3'b111;
            widx[0]  = UpRasPtr;
            widx[1]  = UpRasPtr - ras_ptr_t'(1);
            widx[2]  = UpRasPtr - ras_ptr_t'(2);
            wdata[0] = '{addr: UpRasStack1, cnt: ras_norm_cnt(UpRasStackC1)};
            wdata[1] = '{addr: UpRasStack2, cnt: ras_norm_cnt(UpRasStackC2)};
            wdata[2] = '{addr: UpRasStack3, cnt: ras_norm_cnt(UpRasStackC3)};
        end else if (!RasStop) begin
            if (RasPush && RasPop) begin
                // Return then call: replace the top in place.
                we[0]    = 1'b1;
                wdata[0] = '{addr: RasPushPc, cnt: ras_cnt_t'(1)};
            end else if (RasPush) begin
`ifdef RAS_RECURSION_CNT_EN
                if ((top.cnt != '0) && (top.addr == RasPushPc) &&
                    (top.cnt < ras_cnt_t'(RAS_CNT_MAX))) begin
                    we[0]    = 1'b1;
                    wdata[0] = '{addr: top.addr, cnt: top.cnt + ras_cnt_t'(1)};
                end else begin
                    ptr_d    = ptr_q + ras_ptr_t'(1);
                    we[0]    = 1'b1;
                    widx[0]  = ptr_q + ras_ptr_t'(1);
                    wdata[0] = '{addr: RasPushPc, cnt: ras_cnt_t'(1)};
                end
`else
                ptr_d    = ptr_q + ras_ptr_t'(1);
                we[0]    = 1'b1;
                widx[0]  = ptr_q + ras_ptr_t'(1);
                wdata[0] = '{addr: RasPushPc, cnt: ras_cnt_t'(1)};
`endif
            end else if (RasPop) begin
`ifdef RAS_RECURSION_CNT_EN
                if (top.cnt > ras_cnt_t'(1)) begin
                    we[0]    = 1'b1;
                    wdata[0] = '{addr: top.addr, cnt: top.cnt - ras_cnt_t'(1)};
                end else if (top.cnt != '0) begin
                    ptr_d    = ptr_q - ras_ptr_t'(1);
                    we[0]    = 1'b1;
                    wdata[0] = '{addr: top.addr, cnt: '0};
                end
`else
                if (top.cnt != '0) begin
                    ptr_d    = ptr_q - ras_ptr_t'(1);
                    we[0]    = 1'b1;
                    wdata[0] = '{addr: top.addr, cnt: '0};
                end
`endif
            end
        end
    end

    assign RasStackPc    = top.addr;
    assign RasStackValid = (top.cnt != '0);
    assign RasStackPtr   = ptr_q;
    assign RasStack1     = top.addr;
    assign RasStack2     = nxt1.addr;
    assign RasStack3     = nxt2.addr;
    assign RsaSrackC1    = top.cnt;
    assign RsaSrackC2    = nxt1.cnt;
    assign RsaSrackC3    = nxt2.cnt;

endmodule

// File: tb/tb_ras_predictor.sv
// Self-checking bench for ras_predictor: directed table, corner sequences,
// and randomized traffic against a behavioural stack model.
module tb_ras_predictor;

    logic        Clk = 1'b0;
    logic        Rest;
    logic        RasStop, RasPush, RasPop;
    logic [31:0] RasPushPc;
    logic        UpRasReLoad, UpRasAble;
    logic [3:0]  UpRasPtr;
    logic [31:0] UpRasStack1, UpRasStack2, UpRasStack3;
    logic [6:0]  UpRasStackC1, UpRasStackC2, UpRasStackC3;
    logic [31:0] RasStackPc;
    logic        RasStackValid;
    logic [3:0]  RasStackPtr;
    logic [31:0] RasStack1, RasStack2, RasStack3;
    logic [6:0]  RsaSrackC1, RsaSrackC2, RsaSrackC3;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain arrays indexed modulo 16.
    logic [31:0] m_addr [16];
    int          m_cnt  [16];
    int          m_ptr;

    always #5 Clk = ~Clk;

    ras_predictor dut (
        .Clk(Clk), .Rest(Rest), .RasStop(RasStop), .RasPush(RasPush),
        .RasPushPc(RasPushPc), .RasPop(RasPop), .UpRasReLoad(UpRasReLoad),
        .UpRasAble(UpRasAble), .UpRasPtr(UpRasPtr),
        .UpRasStack1(UpRasStack1), .UpRasStack2(UpRasStack2), .UpRasStack3(UpRasStack3),
        .UpRasStackC1(UpRasStackC1), .UpRasStackC2(UpRasStackC2), .UpRasStackC3(UpRasStackC3),
        .RasStackPc(RasStackPc), .RasStackValid(RasStackValid), .RasStackPtr(RasStackPtr),
        .RasStack1(RasStack1), .RasStack2(RasStack2), .RasStack3(RasStack3),
        .RsaSrackC1(RsaSrackC1), .RsaSrackC2(RsaSrackC2), .RsaSrackC3(RsaSrackC3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        return (v % 16 + 16) % 16;
    endfunction

    function automatic int norm(input int c);
`ifdef RAS_RECURSION_CNT_EN
        return c;
`else
        return (c != 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_addr[i] = '0;
            m_cnt[i]  = 0;
        end
        m_ptr = 0;
    endtask

    // Apply one cycle of the stack rules to the model from the current inputs.
    task automatic model_step();
        if (UpRasReLoad && UpRasAble) begin
            m_ptr = int'(UpRasPtr);
            m_addr[m_ptr] = UpRasStack1; m_cnt[m_ptr] = norm(int'(UpRasStackC1));
            m_addr[wrap(m_ptr-1)] = UpRasStack2; m_cnt[wrap(m_ptr-1)] = norm(int'(UpRasStackC2));
            m_addr[wrap(m_ptr-2)] = UpRasStack3; m_cnt[wrap(m_ptr-2)] = norm(int'(UpRasStackC3));
        end else if (!RasStop) begin
            if (RasPush && RasPop) begin
                m_addr[m_ptr] = RasPushPc;
                m_cnt[m_ptr]  = 1;
            end else if (RasPush) begin
`ifdef RAS_RECURSION_CNT_EN
                if (m_cnt[m_ptr] != 0 && m_addr[m_ptr] == RasPushPc && m_cnt[m_ptr] < 127) begin
                    m_cnt[m_ptr]++;
                end else begin
                    m_ptr = wrap(m_ptr + 1);
                    m_addr[m_ptr] = RasPushPc;
                    m_cnt[m_ptr]  = 1;
                end
`else
                m_ptr = wrap(m_ptr + 1);
                m_addr[m_ptr] = RasPushPc;
                m_cnt[m_ptr]  = 1;
`endif
            end else if (RasPop) begin
                if (m_cnt[m_ptr] > 1) begin
                    m_cnt[m_ptr]--;
                end else if (m_cnt[m_ptr] == 1) begin
                    m_cnt[m_ptr] = 0;
                    m_ptr = wrap(m_ptr - 1);
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ptr"},   32'(RasStackPtr),   32'(m_ptr));
        chk({tag, ".pc"},    RasStackPc,         m_addr[m_ptr]);
        chk({tag, ".valid"}, 32'(RasStackValid), 32'(m_cnt[m_ptr] != 0));
        chk({tag, ".s2"},    RasStack2,          m_addr[wrap(m_ptr-1)]);
        chk({tag, ".s3"},    RasStack3,          m_addr[wrap(m_ptr-2)]);
        chk({tag, ".c1"},    32'(RsaSrackC1),    32'(m_cnt[m_ptr]));
        chk({tag, ".c2"},    32'(RsaSrackC2),    32'(m_cnt[wrap(m_ptr-1)]));
        chk({tag, ".c3"},    32'(RsaSrackC3),    32'(m_cnt[wrap(m_ptr-2)]));
    endtask

    task automatic idle_inputs();
        RasStop = 0; RasPush = 0; RasPop = 0; RasPushPc = '0;
        UpRasReLoad = 0; UpRasAble = 0; UpRasPtr = '0;
        UpRasStack1 = '0; UpRasStack2 = '0; UpRasStack3 = '0;
        UpRasStackC1 = '0; UpRasStackC2 = '0; UpRasStackC3 = '0;
    endtask

    // One clock with the currently driven inputs, then compare against the model.
    task automatic step(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_all(tag);
        $display("step %s push=%0b pop=%0b stop=%0b rst=%0b ptr=%0d pc=%h c1=%0d",
                 tag, RasPush, RasPop, RasStop, UpRasReLoad && UpRasAble,
                 RasStackPtr, RasStackPc, RsaSrackC1);
    endtask

    task automatic do_push(input logic [31:0] pc, input string tag);
        idle_inputs(); RasPush = 1; RasPushPc = pc; step(tag); idle_inputs();
    endtask

    task automatic do_pop(input string tag);
        idle_inputs(); RasPop = 1; step(tag); idle_inputs();
    endtask

    // Asynchronous reset pulse; a restore is held across the release edge and must be dropped.
    task automatic pulse_reset(input string tag);
        Rest = 1;
        #2;
        chk({tag, ".async_ptr"},   32'(RasStackPtr),   32'd0);
        chk({tag, ".async_valid"}, 32'(RasStackValid), 32'd0);
        UpRasReLoad = 1; UpRasAble = 1; UpRasPtr = 4'd7;
        UpRasStack1 = 32'hDEAD; UpRasStackC1 = 7'd3;
        @(posedge Clk);
        #1;
        Rest = 0;
        idle_inputs();
        model_reset();
        #1;
        check_all({tag, ".after"});
    endtask

    typedef struct {
        bit          push;
        bit          pop;
        bit          stop;
        logic [31:0] pc;
        int          e_ptr;
        logic [31:0] e_pc;
        int          e_c1;
        bit          e_valid;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{0, 1, 0, 32'h0,        0, 32'h0,        0, 0};
        tbl[1] = '{1, 0, 0, 32'h1C000010, 1, 32'h1C000010, 1, 1};
        tbl[2] = '{1, 0, 0, 32'h1C000020, 2, 32'h1C000020, 1, 1};
        tbl[3] = '{1, 0, 1, 32'h00000055, 2, 32'h1C000020, 1, 1};
        tbl[4] = '{0, 1, 0, 32'h0,        1, 32'h1C000010, 1, 1};
        tbl[5] = '{0, 1, 0, 32'h0,        0, 32'h0,        0, 0};
        tbl[6] = '{0, 1, 0, 32'h0,        0, 32'h0,        0, 0};

        idle_inputs();
        model_reset();
        Rest = 1;
        repeat (2) @(posedge Clk);
        #1;
        Rest = 0;
        check_all("reset");

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            RasPush = tbl[i].push; RasPop = tbl[i].pop;
            RasStop = tbl[i].stop; RasPushPc = tbl[i].pc;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.ptr", i),   32'(RasStackPtr),   32'(tbl[i].e_ptr));
            chk($sformatf("tbl%0d.pc", i),    RasStackPc,         tbl[i].e_pc);
            chk($sformatf("tbl%0d.c1", i),    32'(RsaSrackC1),    32'(tbl[i].e_c1));
            chk($sformatf("tbl%0d.valid", i), 32'(RasStackValid), 32'(tbl[i].e_valid));
            if (i == 2) chk("tbl2.s2", RasStack2, 32'h1C000010);
        end
        idle_inputs();

        // Recursion handling on repeated identical pushes.
        pulse_reset("rst_rec");
        for (int i = 0; i < 3; i++) do_push(32'h1C000040, "rec3");
`ifdef RAS_RECURSION_CNT_EN
        chk("rec3.ptr", 32'(RasStackPtr), 32'd1);
        chk("rec3.c1",  32'(RsaSrackC1),  32'd3);
        do_pop("rec_pop");
        chk("rec_pop.ptr", 32'(RasStackPtr), 32'd1);
        chk("rec_pop.c1",  32'(RsaSrackC1),  32'd2);
        pulse_reset("rst_sat");
        for (int i = 0; i < 127; i++) do_push(32'h1C000040, "sat");
        chk("sat.ptr", 32'(RasStackPtr), 32'd1);
        chk("sat.c1",  32'(RsaSrackC1),  32'd127);
        do_push(32'h1C000040, "sat128");
        chk("sat128.ptr", 32'(RasStackPtr), 32'd2);
        chk("sat128.c1",  32'(RsaSrackC1),  32'd1);
        chk("sat128.c2",  32'(RsaSrackC2),  32'd127);
`else
        chk("rec3.ptr", 32'(RasStackPtr), 32'd3);
        chk("rec3.c1",  32'(RsaSrackC1),  32'd1);
        do_pop("rec_pop");
        chk("rec_pop.ptr", 32'(RasStackPtr), 32'd2);
        chk("rec_pop.c1",  32'(RsaSrackC1),  32'd1);
`endif

        // Wrap-around: 17 distinct pushes overwrite the oldest slot.
        pulse_reset("rst_wrap");
        for (int i = 0; i < 17; i++) do_push(32'h2000_0000 + 32'(i * 4), "wrap");
        chk("wrap.ptr", 32'(RasStackPtr), 32'd1);
        chk("wrap.top", RasStackPc, 32'h2000_0040);
        chk("wrap.s2",  RasStack2,  32'h2000_003C);

        // Restore wins over a simultaneous push.
        pulse_reset("rst_restore");
        do_push(32'h0000_0AAA, "pushA");
        idle_inputs();
        UpRasReLoad = 1; UpRasAble = 1; UpRasPtr = 4'd5;
        UpRasStack1 = 32'hA; UpRasStackC1 = 7'd2;
        UpRasStack2 = 32'hB; UpRasStackC2 = 7'd1;
        UpRasStack3 = 32'h0; UpRasStackC3 = 7'd0;
        RasPush = 1; RasPushPc = 32'hC;
        step("restore");
        chk("restore.ptr", 32'(RasStackPtr), 32'd5);
        chk("restore.pc",  RasStackPc, 32'hA);
`ifdef RAS_RECURSION_CNT_EN
        chk("restore.c1", 32'(RsaSrackC1), 32'd2);
`else
        chk("restore.c1", 32'(RsaSrackC1), 32'd1);
`endif
        chk("restore.s2", RasStack2, 32'hB);
        idle_inputs();
        UpRasReLoad = 1; UpRasAble = 0; UpRasPtr = 4'd9; UpRasStack1 = 32'hEE; UpRasStackC1 = 7'd4;
        step("restore_noable");
        chk("noable.ptr", 32'(RasStackPtr), 32'd5);
        chk("noable.pc",  RasStackPc, 32'hA);
        idle_inputs();

        // Push and pop together replace the top in place.
        pulse_reset("rst_pp");
        for (int i = 0; i < 3; i++) do_push(32'h100, "pp_fill");
        idle_inputs(); RasPush = 1; RasPop = 1; RasPushPc = 32'h200;
        step("pushpop");
`ifdef RAS_RECURSION_CNT_EN
        chk("pushpop.ptr", 32'(RasStackPtr), 32'd1);
`else
        chk("pushpop.ptr", 32'(RasStackPtr), 32'd3);
`endif
        chk("pushpop.pc", RasStackPc, 32'h200);
        chk("pushpop.c1", 32'(RsaSrackC1), 32'd1);
        RasStop = 1;
        step("stop_pp");
        RasPop = 0; RasPushPc = 32'h300;
        step("stop_push");
        RasPush = 0; RasPop = 1;
        step("stop_pop");
        chk("stop.pc", RasStackPc, 32'h200);
        idle_inputs();

        // Randomized traffic against the model.
        pulse_reset("rst_rand");
        for (int n = 0; n < 1500; n++) begin
            int r;
            idle_inputs();
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                UpRasReLoad = 1;
                UpRasAble = ($urandom_range(0, 3) != 0);
                UpRasPtr = 4'($urandom);
                UpRasStack1 = $urandom; UpRasStack2 = $urandom; UpRasStack3 = $urandom;
                UpRasStackC1 = 7'($urandom); UpRasStackC2 = 7'($urandom_range(0, 2));
                UpRasStackC3 = 7'($urandom_range(0, 1));
            end else if (r < 9) begin
                RasStop = 1;
            end
            RasPush = ($urandom_range(0, 1) == 1);
            RasPop  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: RasPushPc = 32'h1000;
                1: RasPushPc = 32'h1004;
                2: RasPushPc = 32'h2000;
                default: RasPushPc = $urandom;
            endcase
            step($sformatf("rand%0d", n));
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ras_predictor.md
Name: ras_predictor

Overview:
- Return Address Stack (RAS) on the fetch-prediction side of the front end.
- Consumes call/return hints from predecode, supplies the predicted return PC, and exports the current pointer plus the top three entries (address and recursion count) as a snapshot. Downstream logic stores this snapshot alongside each prediction.
- Accepts the matching restore interface (UpRasReLoad/UpRasAble/UpRasPtr/UpRasStack1-3/UpRasStackC1-3) from the commit side, which rewinds the speculative stack after a misprediction.

Parameters:
- RAS_DEPTH, 16: number of stack entries; must be a power of 2; pointer width is log2(RAS_DEPTH) = 4.
- CNT_W, 7: recursion-count width; saturates at 127.

Ports:
- Clk  in  1  clock
- Rest  in  1  asynchronous reset, active-high
- RasStop  in  1  freeze; push/pop ignored while high
- RasPush  in  1  call detected; push RasPushPc
- RasPushPc  in  `InstAddrBus  return address (call PC + 4)
- RasPop  in  1  return detected; pop top
- UpRasReLoad  in  1  restore request
- UpRasAble  in  1  restore data valid; restore happens only when both this and UpRasReLoad are high
- UpRasPtr  in  4  restored top pointer
- UpRasStack1/2/3  in  `InstAddrBus each  restored entries at ptr, ptr-1, ptr-2
- UpRasStackC1/2/3  in  7 each  restored counts for those entries
- RasStackPc  out  `InstAddrBus  predicted return target (address of top entry)
- RasStackValid  out  1  top entry count != 0
- RasStackPtr  out  4  current top pointer
- RasStack1/2/3  out  `InstAddrBus each  entries at ptr, ptr-1, ptr-2
- RsaSrackC1/2/3  out  7 each  counts of those entries

Behaviour:
- State: entry array of {addr[31:0], cnt[6:0]}, plus 4-bit Ptr. An entry with cnt = 0 is empty.
- Reset (async, Rest = 1): all entries are 0 and Ptr = 0. All outputs are therefore 0, including RasStackValid = 0.
- Outputs are combinational reads of registered state. A push or pop in cycle N is visible in cycle N+1.
- Pointer arithmetic is modulo 16, so ptr-1 at Ptr = 0 wraps to 15.
- Priority, highest first: restore, then RasStop, then push/pop.
- Restore: Ptr <= UpRasPtr. entry[UpRasPtr] <= {Stack1, C1}, entry[UpRasPtr-1] <= {Stack2, C2}, entry[UpRasPtr-2] <= {Stack3, C3}. All other entries are unchanged. Any same-cycle push/pop is dropped.
- Push only:
  - If the top cnt != 0, top addr == RasPushPc, and cnt < 127: top cnt += 1 (recursion merge).
  - Otherwise: Ptr <= Ptr+1 and entry[Ptr+1] <= {RasPushPc, 1}. This silently overwrites the oldest entry on wrap; there is no overflow flag.
- Pop only:
  - If top cnt > 1: cnt -= 1 and Ptr is unchanged.
  - If top cnt == 1: entry cnt <= 0 and Ptr <= Ptr-1.
  - If top cnt == 0 (empty): no state change. RasStackValid was already 0.
- Push and pop together (return immediately followed by call): top entry <= {RasPushPc, 1} and Ptr is unchanged.
- RasStop high: state is held. Restore still takes effect.
- Reset asserted mid-operation clears all state immediately. Restore arriving in the same cycle as reset release is ignored.

Optional Feature:
- RAS_RECURSION_CNT_EN
  - Defined: recursion merge on push as described above, and counts decrement on pop.
  - Undefined: every push allocates a new entry with cnt = 1. Every pop of a non-empty top clears it and decrements Ptr. Restored counts are forced to 0 or 1, where any nonzero value becomes 1.

Decomposition:
- Shared package (ras_pkg): RAS_DEPTH, RAS_PTR_W = 4, RAS_CNT_W = 7, RAS_CNT_MAX = 127, and the entry struct/typedef {addr, cnt}. The predictor queue reuses these.
- One sub-module, ras_stack_array: the storage array with three indexed write ports (restore) and three read ports (ptr, ptr-1, ptr-2). Next-state control stays in ras_predictor.

Test Plan:
- Reset -> all outputs 0 and RasStackValid = 0. Pop on empty -> Ptr stays 0, no change.
- Push 0x1C000010 -> next cycle: Ptr = 1, RasStackPc = 0x1C000010, C1 = 1. Push 0x1C000020 -> Ptr = 2, Stack2 = 0x1C000010. Pop twice -> Ptr = 0, Valid = 0.
- With the macro on: push 0x1C000040 three times -> Ptr = 1, C1 = 3. Pop -> C1 = 2, Ptr = 1. Push 127+ times -> count saturates at 127, and the 128th identical push opens a new entry with Ptr = 2.
- Push 17 distinct PCs P0..P16 -> Ptr = 1 (wrapped), entry[1] = P16, RasStack2 = P15 at index 0.
- Push state A, then restore with UpRasReLoad = UpRasAble = 1, Ptr = 5, Stack1 = 0xA, C1 = 2, Stack2 = 0xB, C2 = 1, Stack3 = 0, C3 = 0, with a simultaneous push of 0xC -> next cycle Ptr = 5, RasStackPc = 0xA, C1 = 2, and 0xC is absent. Restore with UpRasAble = 0 -> ignored.
- Push and pop together on top {0x100, 3} with RasPushPc = 0x200 -> top = {0x200, 1} and Ptr is unchanged. With RasStop = 1, push/pop -> no change.
